// File: rtl/icache_refill_ctrl.sv
// Direct-mapped I-cache tag/valid store and line refill sequencer.
// Stalls IF on a miss, streams the line from memory into the instruction RAM.
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    input  logic        invalidate,
    output logic        stall,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        ram_we,
    output logic [29:0] ram_waddr,
    output logic [31:0] ram_wdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q [SETS];
    logic [TAG_W-1:0] lat_tag;
    logic [IDX_W-1:0] lat_idx;
    logic [OFF_W-1:0] beat;
    logic             pend_inv;

    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] f_idx;
    logic             last_beat;
    logic             miss;
    logic             fill_end;
    logic             unused_bits;

    assign f_tag       = fetch_addr[31 -: TAG_W];
    assign f_idx       = fetch_addr[OFF_W+2 +: IDX_W];
    assign unused_bits = ^fetch_addr[1:0];

    assign hit = fetch_valid && valid_q[f_idx] &&
                 (tag_q[f_idx] == f_tag) && (state == IDLE);
    assign miss      = (state == IDLE) && fetch_valid && !hit;
    assign last_beat = (beat == OFF_W'(LINE_WORDS - 1));
    assign fill_end  = (state == FILL) && mem_rvalid && last_beat;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (miss) state_nx = REQ;
            REQ:     if (mem_gnt) state_nx = FILL;
            FILL:    if (mem_rvalid && last_beat) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign stall     = (state != IDLE) || miss;
    assign mem_req   = (state == REQ);
    assign mem_addr  = {lat_tag, lat_idx, {(OFF_W + 2){1'b0}}};
    assign ram_we    = (state == FILL) && mem_rvalid;
    assign ram_waddr = {lat_tag, lat_idx, beat};
    assign ram_wdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            valid_q  <= '0;
            lat_tag  <= '0;
            lat_idx  <= '0;
            beat     <= '0;
            pend_inv <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_nx;
            if (hit) hit_cnt <= hit_cnt + 32'd1;
            if (miss) begin
                lat_tag <= f_tag;
                lat_idx <= f_idx;
            end
            if (state == REQ && mem_gnt) begin
                beat     <= '0;
                miss_cnt <= miss_cnt + 32'd1;
            end
            if (ram_we) beat <= beat + OFF_W'(1);
            if (fill_end) valid_q[lat_idx] <= 1'b1;
            if (invalidate && state != IDLE) pend_inv <= 1'b1;
            // Deferred flush lands after install so the refilled line is dropped too
            if (state == DONE) begin
                pend_inv <= 1'b0;
                if (pend_inv || invalidate) valid_q <= '0;
            end
            if (state == IDLE && invalidate) valid_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && fill_end) tag_q[lat_idx] <= lat_tag;
    end
endmodule
